// File: rtl/param_register_bank_if.sv
// Stream and parallel-output bundle for param_register_bank.
// The master side is the loader/consumer pair; the slave side is the bank.
interface param_register_bank_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    wr_addr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic                    shift_en;
  logic [DEPTH*DATA_W-1:0] out_data;
  logic [DATA_W-1:0]       head_data;
  logic                    out_valid;
  logic                    drain_last;
  logic [ADDR_W:0]         fill_count;

  modport master (
    output in_valid, in_data, wr_addr_en, wr_addr, shift_en,
    input  in_ready, out_data, head_data, out_valid, drain_last, fill_count
  );

  modport slave (
    input  in_valid, in_data, wr_addr_en, wr_addr, shift_en,
    output in_ready, out_data, head_data, out_valid, drain_last, fill_count
  );
endinterface

// File: rtl/param_register_bank.sv
// DEPTH x DATA_W register bank: fills from a valid/ready stream (sequential
// or addressed), exposes all entries in parallel when full, then drains by
// shifting toward entry 0 so head_data feeds a systolic array edge.
module param_register_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  param_register_bank_if.slave bus
);

  typedef enum logic [1:0] {ST_FILL, ST_FULL, ST_DRAIN} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  state_t            state;
  logic [DATA_W-1:0] entry [DEPTH];
  logic [ADDR_W:0]   cnt;
  logic              rdy_q;
  logic              vld_q;

  // A clearing cycle always reports ready, even while full or draining;
  // the beat offered in that cycle is still dropped by the clear.
  assign bus.in_ready   = rdy_q | clear;
  assign bus.out_valid  = vld_q;
  assign bus.fill_count = cnt;
  assign bus.head_data  = entry[0];
  assign bus.drain_last = bus.shift_en & (state == ST_DRAIN) & (cnt == ONE);

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_out
      assign bus.out_data[g*DATA_W +: DATA_W] = entry[g];
    end
  endgenerate

  // Fill/full/drain control plus entry storage; clear has the same effect as reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_FILL;
      cnt   <= '0;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (clear) begin
      state <= ST_FILL;
      cnt   <= '0;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (bus.in_valid) begin
            if (bus.wr_addr_en) begin
              // Out-of-range addresses match no entry and are silently dropped.
              for (int i = 0; i < DEPTH; i++)
                if (int'(bus.wr_addr) == i) entry[i] <= bus.in_data;
            end else begin
              for (int i = 0; i < DEPTH; i++)
                if (int'(cnt) == i) entry[i] <= bus.in_data;
              cnt <= cnt + ONE;
              if (cnt == LAST_IDX) begin
                state <= ST_FULL;
                rdy_q <= 1'b0;
                vld_q <= 1'b1;
              end
            end
          end
        end
        ST_FULL: begin
          if (bus.shift_en) begin
            for (int i = 0; i < DEPTH - 1; i++) entry[i] <= entry[i+1];
            entry[DEPTH-1] <= '0;
            if (DEPTH == 1) begin
              state <= ST_FILL;
              cnt   <= '0;
              rdy_q <= 1'b1;
              vld_q <= 1'b0;
            end else begin
              state <= ST_DRAIN;
              cnt   <= LAST_IDX;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.shift_en) begin
            for (int i = 0; i < DEPTH - 1; i++) entry[i] <= entry[i+1];
            entry[DEPTH-1] <= '0;
            cnt <= cnt - ONE;
            // Last shift: every entry has been shifted out and is now zero.
            if (cnt == ONE) begin
              state <= ST_FILL;
              rdy_q <= 1'b1;
              vld_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_FILL;
          cnt   <= '0;
          rdy_q <= 1'b1;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_register_bank.sv
// Directed bench for param_register_bank: main 8x8 instance plus DEPTH=9
// and DEPTH=10 instances for addressed-write range behaviour.
module tb_param_register_bank;

  logic clk;
  logic reset;
  logic clear;
  int   errors;
  int   checks;

  param_register_bank_if #(.DATA_W(8), .DEPTH(8),  .ADDR_W(3)) b8  ();
  param_register_bank_if #(.DATA_W(8), .DEPTH(9),  .ADDR_W(4)) b9  ();
  param_register_bank_if #(.DATA_W(8), .DEPTH(10), .ADDR_W(4)) b10 ();

  param_register_bank #(.DATA_W(8), .DEPTH(8), .ADDR_W(3)) dut8 (
    .clk(clk), .reset(reset), .clear(clear), .bus(b8));
  param_register_bank #(.DATA_W(8), .DEPTH(9), .ADDR_W(4)) dut9 (
    .clk(clk), .reset(reset), .clear(clear), .bus(b9));
  param_register_bank #(.DATA_W(8), .DEPTH(10), .ADDR_W(4)) dut10 (
    .clk(clk), .reset(reset), .clear(clear), .bus(b10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One beat on the 8-deep bank; called and returns at posedge+1.
  task automatic beat(input logic [7:0] d, input logic ae, input logic [2:0] a);
    b8.in_valid   = 1'b1;
    b8.in_data    = d;
    b8.wr_addr_en = ae;
    b8.wr_addr    = a;
    @(posedge clk); #1;
    b8.in_valid   = 1'b0;
    b8.wr_addr_en = 1'b0;
  endtask

  task automatic fill8(input logic [7:0] step);
    for (int k = 0; k < 8; k++) beat(8'((k + 1) * step), 1'b0, 3'd0);
  endtask

  task automatic shift_n(input int n);
    b8.shift_en = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    b8.shift_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (b8.fill_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", b8.fill_count); end
    checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", b8.in_ready); end
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", b8.out_valid); end
    checks++; if (b8.out_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", b8.out_data); end
    checks++; if (b8.drain_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", b8.drain_last); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_seq_fill();
    for (int k = 0; k < 7; k++) beat(8'((k + 1) * 8'h11), 1'b0, 3'd0);
    checks++; if (b8.fill_count !== 4'd7) begin errors++; $display("FAIL seq_count7: got %0d expected 7", b8.fill_count); end
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_early: got %b expected 0", b8.out_valid); end
    beat(8'h88, 1'b0, 3'd0);
    checks++; if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b expected 1", b8.out_valid); end
    checks++; if (b8.in_ready !== 1'b0) begin errors++; $display("FAIL seq_ready: got %b expected 0", b8.in_ready); end
    checks++; if (b8.fill_count !== 4'd8) begin errors++; $display("FAIL seq_count8: got %0d expected 8", b8.fill_count); end
    checks++; if (b8.out_data !== 64'h8877665544332211) begin errors++; $display("FAIL seq_data: got %h expected 8877665544332211", b8.out_data); end
    // in_valid held while FULL must not disturb the bank
    b8.in_valid = 1'b1; b8.in_data = 8'hEE;
    repeat (2) begin @(posedge clk); #1; end
    b8.in_valid = 1'b0;
    checks++; if (b8.out_data !== 64'h8877665544332211) begin errors++; $display("FAIL full_ignore_data: got %h expected 8877665544332211", b8.out_data); end
    checks++; if (b8.fill_count !== 4'd8) begin errors++; $display("FAIL full_ignore_count: got %0d expected 8", b8.fill_count); end
  endtask

  task automatic test_drain();
    b8.shift_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (b8.head_data !== 8'((k + 1) * 8'h11)) begin errors++; $display("FAIL drain_head%0d: got %h expected %h", k, b8.head_data, 8'((k + 1) * 8'h11)); end
      checks++; if (b8.drain_last !== (k == 7)) begin errors++; $display("FAIL drain_last%0d: got %b expected %b", k, b8.drain_last, (k == 7)); end
      @(posedge clk); #1;
      if (k == 0) begin
        checks++; if (b8.fill_count !== 4'd7) begin errors++; $display("FAIL drain_first_count: got %0d expected 7", b8.fill_count); end
      end
    end
    b8.shift_en = 1'b0;
    checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL drain_end_ready: got %b expected 1", b8.in_ready); end
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL drain_end_valid: got %b expected 0", b8.out_valid); end
    checks++; if (b8.out_data !== 64'h0) begin errors++; $display("FAIL drain_end_data: got %h expected 0", b8.out_data); end
    checks++; if (b8.fill_count !== 4'd0) begin errors++; $display("FAIL drain_end_count: got %0d expected 0", b8.fill_count); end
  endtask

  task automatic test_addr_write();
    beat(8'hA5, 1'b1, 3'd5);
    checks++; if (b8.out_data[5*8 +: 8] !== 8'hA5) begin errors++; $display("FAIL addr_entry5: got %h expected a5", b8.out_data[5*8 +: 8]); end
    checks++; if (b8.fill_count !== 4'd0) begin errors++; $display("FAIL addr_count: got %0d expected 0", b8.fill_count); end
    fill8(8'h01);
    checks++; if (b8.out_data[5*8 +: 8] !== 8'h06) begin errors++; $display("FAIL addr_overwrite: got %h expected 06", b8.out_data[5*8 +: 8]); end
    checks++; if (b8.out_data !== 64'h0807060504030201) begin errors++; $display("FAIL addr_fill_data: got %h expected 0807060504030201", b8.out_data); end
  endtask

  task automatic test_pause_drain();
    logic [1:0] pat [4];
    pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd0; pat[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      b8.shift_en = pat[k][0];
      @(posedge clk); #1;
      if (k == 1 || k == 2) begin
        checks++; if (b8.out_data !== 64'h0008070605040302) begin errors++; $display("FAIL pause_frozen%0d: got %h expected 0008070605040302", k, b8.out_data); end
      end
    end
    b8.shift_en = 1'b0;
    checks++; if (b8.fill_count !== 4'd6) begin errors++; $display("FAIL pause_count: got %0d expected 6", b8.fill_count); end
    checks++; if (b8.out_data !== 64'h0000080706050403) begin errors++; $display("FAIL pause_data: got %h expected 0000080706050403", b8.out_data); end
    b8.in_valid = 1'b1; b8.in_data = 8'hFF;
    repeat (2) begin @(posedge clk); #1; end
    b8.in_valid = 1'b0;
    checks++; if (b8.out_data !== 64'h0000080706050403) begin errors++; $display("FAIL drain_ignore_data: got %h expected 0000080706050403", b8.out_data); end
    checks++; if (b8.in_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %b expected 0", b8.in_ready); end
    clear = 1'b1;
    #1;
    checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL clear_ready_drain: got %b expected 1", b8.in_ready); end
    @(posedge clk); #1;
    clear = 1'b0;
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL clear_drain_valid: got %b expected 0", b8.out_valid); end
  endtask

  task automatic test_clear();
    beat(8'h31, 1'b0, 3'd0);
    beat(8'h32, 1'b0, 3'd0);
    beat(8'h33, 1'b0, 3'd0);
    checks++; if (b8.fill_count !== 4'd3) begin errors++; $display("FAIL clear_pre_count: got %0d expected 3", b8.fill_count); end
    clear = 1'b1;
    b8.in_valid = 1'b1; b8.in_data = 8'h44;
    @(posedge clk); #1;
    clear = 1'b0; b8.in_valid = 1'b0;
    checks++; if (b8.fill_count !== 4'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", b8.fill_count); end
    checks++; if (b8.out_data !== 64'h0) begin errors++; $display("FAIL clear_data: got %h expected 0", b8.out_data); end
  endtask

  task automatic test_async_reset();
    fill8(8'h11);
    shift_n(3);
    #2 reset = 1'b0;
    #1;
    checks++; if (b8.fill_count !== 4'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", b8.fill_count); end
    checks++; if (b8.out_data !== 64'h0) begin errors++; $display("FAIL areset_data: got %h expected 0", b8.out_data); end
    checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", b8.out_valid); end
    checks++; if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b expected 1", b8.in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    fill8(8'h11);
    checks++; if (b8.out_data !== 64'h8877665544332211) begin errors++; $display("FAIL refill_data: got %h expected 8877665544332211", b8.out_data); end
    checks++; if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL refill_valid: got %b expected 1", b8.out_valid); end
  endtask

  task automatic test_addr_range();
    b9.in_valid = 1'b1;  b9.wr_addr_en = 1'b1;  b9.wr_addr = 4'd9;  b9.in_data = 8'h5A;
    b10.in_valid = 1'b1; b10.wr_addr_en = 1'b1; b10.wr_addr = 4'd9; b10.in_data = 8'h5A;
    @(posedge clk); #1;
    b9.wr_addr = 4'd8; b9.in_data = 8'h3C;
    b10.in_valid = 1'b0; b10.wr_addr_en = 1'b0;
    checks++; if (b9.out_data !== 72'h0) begin errors++; $display("FAIL range9_discard: got %h expected 0", b9.out_data); end
    checks++; if (b10.out_data[9*8 +: 8] !== 8'h5A) begin errors++; $display("FAIL range10_entry9: got %h expected 5a", b10.out_data[9*8 +: 8]); end
    checks++; if (b10.fill_count !== 5'd0) begin errors++; $display("FAIL range10_count: got %0d expected 0", b10.fill_count); end
    @(posedge clk); #1;
    b9.in_valid = 1'b0; b9.wr_addr_en = 1'b0;
    checks++; if (b9.out_data !== {8'h3C, 64'h0}) begin errors++; $display("FAIL range9_entry8: got %h expected 3c0000000000000000", b9.out_data); end
    checks++; if (b9.fill_count !== 5'd0) begin errors++; $display("FAIL range9_count: got %0d expected 0", b9.fill_count); end
  endtask

  initial begin
    errors = 0; checks = 0;
    clear = 1'b0; reset = 1'b0;
    b8.in_valid = 1'b0;  b8.in_data = '0;  b8.wr_addr_en = 1'b0;  b8.wr_addr = '0;  b8.shift_en = 1'b0;
    b9.in_valid = 1'b0;  b9.in_data = '0;  b9.wr_addr_en = 1'b0;  b9.wr_addr = '0;  b9.shift_en = 1'b0;
    b10.in_valid = 1'b0; b10.in_data = '0; b10.wr_addr_en = 1'b0; b10.wr_addr = '0; b10.shift_en = 1'b0;
    test_reset();
    test_seq_fill();
    test_drain();
    test_addr_write();
    test_pause_drain();
    test_clear();
    test_async_reset();
    test_addr_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_register_bank.md
Name: param_register_bank

Overview:
- Parametrised successor to the fixed 8x8 register bank. It provides a DEPTH-entry bank of DATA_W-bit registers.
- The bank fills from a valid/ready stream, using either sequential auto-increment or addressed writes.
- All entries are exposed in parallel once full. A drain mode shifts entries toward index 0 to feed a systolic array row one word per cycle.
- Sits between the weight/activation loader and a systolic array edge.

Parameters:
- DATA_W, 8, width of each entry in bits.
- DEPTH, 8, number of entries (2 or more; need not be a power of 2).
- ADDR_W, 3, address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear: all entries, count and state return to reset values.
- in_valid  input  1  in_data beat offered.
- in_ready  output  1  bank accepts a beat.
- in_data  input  DATA_W  write data.
- wr_addr_en  input  1  when 1, the beat writes entry wr_addr instead of the sequential pointer.
- wr_addr  input  ADDR_W  addressed-write target.
- shift_en  input  1  advance drain by one entry.
- out_data  output  DEPTH*DATA_W  all entries; entry i at bits [i*DATA_W +: DATA_W].
- head_data  output  DATA_W  entry 0.
- out_valid  output  1  bank full (state FULL or DRAIN).
- drain_last  output  1  the current shift is the final one of a drain.
- fill_count  output  ADDR_W+1  sequential words loaded (FILL) or words remaining (DRAIN).

Behaviour:
- Reset (reset=0, asynchronous): every entry 0, fill_count 0, state FILL, in_ready 1, out_valid 0, drain_last 0.
- Accept condition: a beat is accepted when in_valid & in_ready at a rising edge. The written entry is visible on out_data the following cycle (latency 1).
- FILL state:
  - in_ready=1.
  - Sequential beat (wr_addr_en=0): writes entry fill_count, then fill_count+1.
  - Addressed beat (wr_addr_en=1): writes entry wr_addr; fill_count unchanged. A wr_addr >= DEPTH is accepted and discarded (no entry changes).
  - A sequential beat at fill_count=DEPTH-1 writes the last entry, sets fill_count=DEPTH and moves to FULL. out_valid is 1 the next cycle.
  - shift_en is ignored.
- FULL state:
  - in_ready=0, out_valid=1; in_valid is ignored.
  - shift_en=1: first shift occurs on this edge, fill_count becomes DEPTH-1, and the state moves to DRAIN. If DEPTH-1=0, the state moves to FILL instead.
- Shift operation: entry[i] <= entry[i+1] for i < DEPTH-1; entry[DEPTH-1] <= 0. head_data before the edge is the word consumed.
- DRAIN state:
  - in_ready=0, out_valid=1.
  - Each cycle with shift_en=1 performs one shift and decrements fill_count. shift_en=0 pauses with no change.
  - drain_last = shift_en & (fill_count==1) (combinational). On that shift, the state goes to FILL with fill_count=0 and all entries already zero.
- Priority: reset > clear > state operation. clear asserted together with an accepted beat or a shift: clear wins and the beat is dropped. in_ready is 1 during a clear cycle, but the beat is not stored.
- A DEPTH-word drain therefore takes exactly DEPTH shift cycles: 1 in FULL and DEPTH-1 in DRAIN.
- Reset asserted mid-fill or mid-drain: immediate return to reset values; no partial state survives.
- No arithmetic beyond counters; fill_count never exceeds DEPTH and never wraps.

Test Plan:
- Reset then 8 sequential beats 0x11..0x88 (DATA_W=8, DEPTH=8) -> entry0=0x11 ... entry7=0x88; out_valid rises the cycle after the 8th beat; in_ready=0.
- Addressed write 0xA5 to wr_addr=5 during FILL, then 8 sequential beats 0x01..0x08 -> entry5 ends 0x06 (sequential overwrite); fill_count unaffected by the addressed beat. Also wr_addr=9 with DEPTH=10, ADDR_W=4 vs DEPTH=9 -> discarded.
- Full bank 0x11..0x88, shift_en held 8 cycles -> head_data sequence 0x11,0x22,...,0x88 before each edge; drain_last only on the 8th; then FILL, all entries 0, in_ready=1.
- Drain with shift_en toggling 1,0,0,1 -> only 2 shifts; fill_count 6; out_data frozen during the 0 cycles.
- in_valid held high in FULL/DRAIN -> no entry changes; clear with in_valid=1 in FILL at fill_count=3 -> fill_count 0, all entries 0, beat dropped.
- reset pulsed low asynchronously mid-drain (between edges) -> outputs at reset values immediately; after release, a fresh 8-beat fill works normally.
